// File: rtl/synth_pkg.sv
// Shared types for the synth note-event front end: MIDI status nibbles,
// message kinds, FSM encodings and the voice-table entry.
package synth_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;

   typedef enum logic [1:0] {K_ON, K_OFF, K_AT} msg_kind_t;

   typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2} pstate_t;

   typedef enum logic [1:0] {D_IDLE, D_SCAN, D_EMIT} dstate_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] channel;
      logic [6:0] note;
   } voice_t;

   typedef struct packed {
      msg_kind_t  kind;
      logic [3:0] channel;
      logic [6:0] note;
      logic [6:0] velocity;
   } note_msg_t;

endpackage

// File: rtl/midi_parser.sv
// MIDI byte-stream parser with running status; flags completed note-on,
// note-off and poly-aftertouch messages combinationally on the completing byte.
module midi_parser
   import synth_pkg::*;
(
   input  logic       clk32,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic       msg_valid,
   output note_msg_t  msg
);

   pstate_t    state, state_n;
   logic       rs_vld, rs_vld_n;
   logic [7:0] rs, rs_n;
   logic [6:0] d1, d1_n;
   logic       one_byte;

   assign one_byte = (rs[7:4] == 4'hC) || (rs[7:4] == 4'hD);

   always_ff @(posedge clk32) begin
      if (rst) begin
         state  <= P_IDLE;
         rs_vld <= 1'b0;
         rs     <= '0;
         d1     <= '0;
      end else begin
         state  <= state_n;
         rs_vld <= rs_vld_n;
         rs     <= rs_n;
         d1     <= d1_n;
      end
   end

   always_comb begin
      state_n   = state;
      rs_vld_n  = rs_vld;
      rs_n      = rs;
      d1_n      = d1;
      msg_valid = 1'b0;
      msg       = '0;
      // Realtime bytes (F8-FF) fall through untouched.
      if (rx_valid && rx_byte < 8'hF8) begin
         if (rx_byte[7:4] == 4'hF) begin
            rs_vld_n = 1'b0;
            state_n  = P_IDLE;
         end else if (rx_byte[7]) begin
            rs_vld_n = 1'b1;
            rs_n     = rx_byte;
            state_n  = P_DATA1;
         end else begin
            case (state)
               P_IDLE, P_DATA1: begin
                  if (rs_vld) begin
                     d1_n    = rx_byte[6:0];
                     state_n = one_byte ? P_IDLE : P_DATA2;
                  end
               end
               P_DATA2: begin
                  state_n      = P_IDLE;
                  msg.channel  = rs[3:0];
                  msg.note     = d1;
                  msg.velocity = rx_byte[6:0];
                  case (rs[7:4])
                     NOTE_ON: begin
                        msg_valid = 1'b1;
                        msg.kind  = (rx_byte[6:0] == 7'd0) ? K_OFF : K_ON;
                     end
                     NOTE_OFF: begin
                        msg_valid = 1'b1;
                        msg.kind  = K_OFF;
                     end
                     POLY_AT: begin
                        msg_valid = 1'b1;
                        msg.kind  = K_AT;
                     end
                     default: ;
                  endcase
               end
               default: state_n = P_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/midi_note_dispatch.sv
// Note dispatcher: 1-deep pending buffer, voice table, linear scan allocator.
// Define VOICE_STEAL_EN to steal a slot round-robin when the table is full.
module midi_note_dispatch
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 128
)
(
   input  logic       clk32,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic       note_pressed,
   output logic       note_released,
   output logic       note_keypress,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic [3:0] channel,
   output logic [7:0] addr,
   output logic       busy,
   output logic       overflow
);

   localparam int            IW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

   logic          msg_valid;
   note_msg_t     msg, pend, cur;
   logic          pend_full, take, last, hit;
   dstate_t       dstate, dstate_n;
   voice_t        vtab [NUM_VOICES];
   voice_t        ent;
   logic [IW-1:0] idx, m_idx, f_idx, m_idx_n, f_idx_n, slot;
   logic          m_found, f_found, m_found_n, f_found_n;
   logic          act_press, act_rel, act_kp;
`ifdef VOICE_STEAL_EN
   logic [IW-1:0] steal_ptr;
   logic          act_steal;
`endif

   midi_parser u_parser (
      .clk32     (clk32),
      .rst       (rst),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .msg_valid (msg_valid),
      .msg       (msg)
   );

   assign take      = (dstate == D_IDLE) && pend_full;
   assign last      = (idx == LAST);
   assign ent       = vtab[idx];
   assign hit       = ent.valid && (ent.channel == cur.channel) && (ent.note == cur.note);
   assign m_found_n = m_found | hit;
   assign m_idx_n   = m_found ? m_idx : idx;
   assign f_found_n = f_found | ~ent.valid;
   assign f_idx_n   = f_found ? f_idx : idx;
   assign busy      = pend_full || (dstate != D_IDLE);

   always_ff @(posedge clk32) begin
      if (rst) dstate <= D_IDLE;
      else     dstate <= dstate_n;
   end

   // The decision is taken on the last scan edge so the strobe lands in D_EMIT.
   always_comb begin
      dstate_n  = dstate;
      act_press = 1'b0;
      act_rel   = 1'b0;
      act_kp    = 1'b0;
      slot      = m_idx_n;
`ifdef VOICE_STEAL_EN
      act_steal = 1'b0;
`endif
      case (dstate)
         D_IDLE: if (pend_full) dstate_n = D_SCAN;
         D_SCAN: begin
            if (last) begin
               dstate_n = D_EMIT;
               case (cur.kind)
                  K_ON: begin
                     if (m_found_n) begin
                        act_press = 1'b1;
                     end else if (f_found_n) begin
                        act_press = 1'b1;
                        slot      = f_idx_n;
                     end
`ifdef VOICE_STEAL_EN
                     else begin
                        act_press = 1'b1;
                        act_steal = 1'b1;
                        slot      = steal_ptr;
                     end
`endif
                  end
                  K_OFF:   act_rel = m_found_n;
                  K_AT:    act_kp  = m_found_n;
                  default: ;
               endcase
            end
         end
         default: dstate_n = D_IDLE;
      endcase
   end

   always_ff @(posedge clk32) begin
      if (rst) begin
         pend_full     <= 1'b0;
         pend          <= '0;
         cur           <= '0;
         idx           <= '0;
         m_idx         <= '0;
         f_idx         <= '0;
         m_found       <= 1'b0;
         f_found       <= 1'b0;
         note_pressed  <= 1'b0;
         note_released <= 1'b0;
         note_keypress <= 1'b0;
         overflow      <= 1'b0;
         note          <= '0;
         velocity      <= '0;
         channel       <= '0;
         addr          <= '0;
         for (int i = 0; i < NUM_VOICES; i++) vtab[i] <= '0;
`ifdef VOICE_STEAL_EN
         steal_ptr     <= '0;
`endif
      end else begin
         note_pressed  <= act_press;
         note_released <= act_rel;
         note_keypress <= act_kp;
         overflow      <= msg_valid && pend_full && !take;
         // A buffer freed this cycle may be refilled on the same edge.
         if (msg_valid && (!pend_full || take)) begin
            pend_full <= 1'b1;
            pend      <= msg;
         end else if (take) begin
            pend_full <= 1'b0;
         end
         if (take) begin
            cur     <= pend;
            idx     <= '0;
            m_found <= 1'b0;
            f_found <= 1'b0;
         end else if (dstate == D_SCAN) begin
            idx     <= last ? '0 : idx + IW'(1);
            m_found <= m_found_n;
            m_idx   <= m_idx_n;
            f_found <= f_found_n;
            f_idx   <= f_idx_n;
         end
         if (act_press) vtab[slot] <= '{valid: 1'b1, channel: cur.channel, note: cur.note};
         if (act_rel)   vtab[slot] <= '0;
         if (act_press || act_rel || act_kp) begin
            note     <= cur.note;
            velocity <= cur.velocity;
            channel  <= cur.channel;
            addr     <= 8'(slot);
         end
`ifdef VOICE_STEAL_EN
         if (act_steal) steal_ptr <= (steal_ptr == LAST) ? '0 : steal_ptr + IW'(1);
`endif
      end
   end

endmodule

// File: tb/tb_midi_note_dispatch.sv
// Randomized + directed bench for midi_note_dispatch at NUM_VOICES 4 and 128,
// checked every cycle against a message-level reference model.
module tb_midi_note_dispatch;

   logic clk32 = 1'b0;
   always #5 clk32 = ~clk32;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int kind;   // 0 note-on, 1 note-off, 2 aftertouch
      int ch;
      int note;
      int vel;
   } msg_s;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int NV = (g == 0) ? 4 : 128;

      logic       rst;
      logic [7:0] rx_byte;
      logic       rx_valid;
      logic       note_pressed, note_released, note_keypress, busy, overflow;
      logic [6:0] note, velocity;
      logic [3:0] channel;
      logic [7:0] addr;
      bit         done = 1'b0;

      midi_note_dispatch #(.NUM_VOICES(NV)) dut (
         .clk32         (clk32),
         .rst           (rst),
         .rx_byte       (rx_byte),
         .rx_valid      (rx_valid),
         .note_pressed  (note_pressed),
         .note_released (note_released),
         .note_keypress (note_keypress),
         .note          (note),
         .velocity      (velocity),
         .channel       (channel),
         .addr          (addr),
         .busy          (busy),
         .overflow      (overflow)
      );

      // Reference model state
      int         cyc_k;
      bit         rs_vld, have;
      logic [7:0] rs;
      logic [6:0] d1;
      bit         pend_full;
      msg_s       pend, cur;
      int         next_take, resolve_at, busy_until;
      bit         tv [NV];
      int         tc [NV];
      int         tn [NV];
      int         sp;
      int         e_press, e_rel, e_kp, e_note, e_vel, e_ch, e_addr, e_ovf, e_busy;

      function automatic string tg(input string s);
         return $sformatf("n%0d_%s", NV, s);
      endfunction

      task automatic model_reset();
         rs_vld = 0; have = 0; rs = '0; d1 = '0;
         pend_full = 0; next_take = 0; resolve_at = -1; busy_until = -1; sp = 0;
         for (int i = 0; i < NV; i++) begin tv[i] = 0; tc[i] = 0; tn[i] = 0; end
         e_press = 0; e_rel = 0; e_kp = 0; e_ovf = 0; e_busy = 0;
         e_note = 0; e_vel = 0; e_ch = 0; e_addr = 0;
      endtask

      task automatic parse(input bit v, input logic [7:0] b, output bit comp, output msg_s m);
         int st;
         comp = 0;
         m = '{0, 0, 0, 0};
         if (!v || b >= 8'hF8) return;
         if (b >= 8'hF0) begin rs_vld = 0; have = 0; return; end
         if (b[7]) begin rs = b; rs_vld = 1; have = 0; return; end
         if (!rs_vld) return;
         st = int'(rs[7:4]);
         if (st == 12 || st == 13) begin have = 0; return; end
         if (!have) begin d1 = b[6:0]; have = 1; return; end
         have = 0;
         if (st == 8 || st == 9 || st == 10) begin
            comp   = 1;
            m.ch   = int'(rs[3:0]);
            m.note = int'(d1);
            m.vel  = int'(b[6:0]);
            m.kind = (st == 10) ? 2 : ((st == 9 && b != 8'h00) ? 0 : 1);
         end
      endtask

      task automatic resolve();
         int m_i = -1;
         int f_i = -1;
         int slot = -1;
         for (int i = 0; i < NV; i++) begin
            if (m_i < 0 && tv[i] && tc[i] == cur.ch && tn[i] == cur.note) m_i = i;
            if (f_i < 0 && !tv[i]) f_i = i;
         end
         case (cur.kind)
            0: begin
               if (m_i >= 0) slot = m_i;
               else if (f_i >= 0) slot = f_i;
`ifdef VOICE_STEAL_EN
               else begin slot = sp; sp = (sp + 1) % NV; end
`endif
               if (slot >= 0) begin
                  tv[slot] = 1; tc[slot] = cur.ch; tn[slot] = cur.note; e_press = 1;
               end
            end
            1: if (m_i >= 0) begin slot = m_i; tv[slot] = 0; e_rel = 1; end
            default: if (m_i >= 0) begin slot = m_i; e_kp = 1; end
         endcase
         if (slot >= 0) begin
            e_note = cur.note; e_vel = cur.vel; e_ch = cur.ch; e_addr = slot;
         end
      endtask

      // Expected outputs after clock edge number cyc_k. A message taken at
      // edge t resolves at t+NV, and the next take is possible at t+NV+2.
      task automatic model_edge(input bit v, input logic [7:0] b, input bit r);
         bit   took, comp;
         msg_s m;
         cyc_k++;
         e_press = 0; e_rel = 0; e_kp = 0; e_ovf = 0;
         if (r) begin model_reset(); return; end
         if (cyc_k == resolve_at) resolve();
         took = 0;
         if (pend_full && cyc_k >= next_take) begin
            cur = pend; took = 1;
            resolve_at = cyc_k + NV; next_take = cyc_k + NV + 2; busy_until = cyc_k + NV;
         end
         parse(v, b, comp, m);
         if (comp) begin
            if (pend_full && !took) e_ovf = 1;
            else begin pend = m; pend_full = 1; end
         end else if (took) begin
            pend_full = 0;
         end
         e_busy = (pend_full || cyc_k <= busy_until) ? 1 : 0;
      endtask

      task automatic cyc(input bit v, input logic [7:0] b, input bit r);
         rx_valid = v; rx_byte = b; rst = r;
         @(posedge clk32);
         model_edge(v, b, r);
         @(negedge clk32);
         chk(tg("pressed"),  note_pressed,  e_press);
         chk(tg("released"), note_released, e_rel);
         chk(tg("keypress"), note_keypress, e_kp);
         chk(tg("overflow"), overflow,      e_ovf);
         chk(tg("busy"),     busy,          e_busy);
         chk(tg("note"),     note,          e_note);
         chk(tg("velocity"), velocity,      e_vel);
         chk(tg("channel"),  channel,       e_ch);
         chk(tg("addr"),     addr,          e_addr);
      endtask

      task automatic send(input logic [7:0] b); cyc(1'b1, b, 1'b0); endtask
      task automatic idle(input int n); repeat (n) cyc(1'b0, 8'h00, 1'b0); endtask
      task automatic do_rst(); repeat (2) cyc(1'b0, 8'h00, 1'b1); endtask
      task automatic drain();
         int guard = 0;
         while (e_busy != 0 && guard < 1000) begin cyc(1'b0, 8'h00, 1'b0); guard++; end
         idle(2);
      endtask

      initial begin
         logic [7:0] b;
         int         k;
         cyc_k = 0;
         model_reset();
         rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
         @(negedge clk32);
         do_rst();
         idle(1);

         // note on / off
         send(8'h93); send(8'h3C); send(8'h64); drain();
         send(8'h83); send(8'h3C); send(8'h00); drain();

         // running status, vel-0 release, realtime mid-message
         send(8'h90); send(8'h40); send(8'h50); drain();
         send(8'h41); send(8'h50); drain();
         send(8'h40); send(8'hF8); send(8'h00); drain();

         // aftertouch on held 0x41, release of an unheld note
         send(8'hA0); send(8'h41); send(8'h20); drain();
         send(8'h80); send(8'h7F); send(8'h00); drain();

         // fill table and overrun it by two
         do_rst();
         for (int i = 0; i < NV + 2; i++) begin
            b = 8'h95 + 8'(i >> 7);
            send(b); send(8'(i & 127)); send(8'h40); drain();
         end
         send(8'hA5); send(8'((NV - 1) & 127)); send(8'h20); drain();
         send(8'h89); send(8'h11); send(8'h00); drain();

         // back-to-back running-status note-ons
         do_rst();
         send(8'h90); send(8'h10); send(8'h40); send(8'h11); send(8'h40);
         send(8'h12); send(8'h40); drain();

         // reset mid-scan
         k = (NV > 10) ? 10 : 2;
         send(8'h90); send(8'h20); send(8'h40);
         idle(1 + k);
         cyc(1'b0, 8'h00, 1'b1);
         idle(2);
         send(8'h90); send(8'h21); send(8'h40); drain();

         // random traffic
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) begin
               idle(1);
            end else begin
               case ($urandom_range(0, 15))
                  0:       b = 8'h80 | 8'($urandom_range(0, 1));
                  1, 2:    b = 8'h90 | 8'($urandom_range(0, 1));
                  3:       b = 8'hA0 | 8'($urandom_range(0, 1));
                  4:       b = 8'hF8;
                  5:       b = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'hC0;
                  6:       b = 8'hB0;
                  default: b = ($urandom_range(0, 1) != 0) ? 8'h3C + 8'($urandom_range(0, 3))
                             : (($urandom_range(0, 3) == 0) ? 8'h00 : 8'h40);
               endcase
               send(b);
            end
         end
         drain();
         done = 1'b1;
      end
   end

   initial begin
      wait (cfg[0].done && cfg[1].done);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected done");
      $fatal(1, "watchdog");
   end

endmodule
